// File: rtl/k_and_s_pkg.sv
// Shared definitions for the program-memory block: FSM state encoding and default geometry.
package k_and_s_pkg;

   localparam int K_AND_S_ADDR_W = 5;
   localparam int K_AND_S_DATA_W = 16;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } mem_state_t;

endpackage

// File: rtl/k_and_s_program_memory.sv
// Program memory: streams a loader image, then releases the processor with a zero-latency read port; writes take effect at the rising edge.
// Backpressure: loader words are accepted only in LOAD. K_AND_S_MEM_ZERO_FILL_EN clears the unloaded tail before release.
module k_and_s_program_memory
   import k_and_s_pkg::*;
#(
   parameter int ADDR_W = K_AND_S_ADDR_W,
   parameter int DATA_W = K_AND_S_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic [ADDR_W:0]   load_count,
   output logic              cpu_run,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic              ram_write_enable,
   input  logic [DATA_W-1:0] ram_wdata,
   output logic [DATA_W-1:0] ram_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   mem_state_t        state;
   mem_state_t        next_state;
   logic [ADDR_W-1:0] ptr;
   logic              ptr_last;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              ptr_step;
   logic              word_accept;

   assign ptr_last    = &ptr;
   assign word_accept = (state == LOAD) && load_valid;
   assign ptr_step    = (word_accept || (state == FILL)) && !ptr_last;

   always_comb begin
      next_state = state;
      load_ready = 1'b0;
      cpu_run    = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = ptr;
      mem_wdata  = load_data;
      case (state)
         LOAD: begin
            load_ready = 1'b1;
            if (load_valid) begin
               mem_we = 1'b1;
               if (ptr_last) begin
                  next_state = RUN;
               end else if (load_last) begin
`ifdef K_AND_S_MEM_ZERO_FILL_EN
                  next_state = FILL;
`else
                  next_state = RUN;
`endif
               end
            end
         end
`ifdef K_AND_S_MEM_ZERO_FILL_EN
         FILL: begin
            mem_we    = 1'b1;
            mem_wdata = '0;
            if (ptr_last) begin
               next_state = RUN;
            end
         end
`endif
         RUN: begin
            cpu_run   = 1'b1;
            mem_we    = ram_write_enable;
            mem_waddr = ram_addr;
            mem_wdata = ram_wdata;
         end
         default: begin
            next_state = LOAD;
         end
      endcase
   end

   // Pointer parks on the last word rather than wrapping; the state change ends the sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOAD;
         ptr        <= '0;
         load_count <= '0;
      end else begin
         state <= next_state;
         if (ptr_step) begin
            ptr <= ptr + 1'b1;
         end
         if (word_accept && (load_count != FULL_COUNT)) begin
            load_count <= load_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign ram_rdata = mem[ram_addr];

endmodule

// File: tb/tb_k_and_s_program_memory.sv
// Directed bench for k_and_s_program_memory; expectations follow K_AND_S_MEM_ZERO_FILL_EN when defined.
module tb_k_and_s_program_memory;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;

`ifdef K_AND_S_MEM_ZERO_FILL_EN
   localparam int EXP_FILL_CYCLES = 29;
`else
   localparam int EXP_FILL_CYCLES = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_valid = 1'b0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_last = 1'b0;
   logic              load_ready;
   logic [ADDR_W:0]   load_count;
   logic              cpu_run;
   logic [ADDR_W-1:0] ram_addr = '0;
   logic              ram_write_enable = 1'b0;
   logic [DATA_W-1:0] ram_wdata = '0;
   logic [DATA_W-1:0] ram_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   k_and_s_program_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .load_valid       (load_valid),
      .load_data        (load_data),
      .load_last        (load_last),
      .load_ready       (load_ready),
      .load_count       (load_count),
      .cpu_run          (cpu_run),
      .ram_addr         (ram_addr),
      .ram_write_enable (ram_write_enable),
      .ram_wdata        (ram_wdata),
      .ram_rdata        (ram_rdata)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic read_chk(input string tag, input int addr, input logic [15:0] exp);
      ram_addr = ADDR_W'(addr);
      #1;
      chk(tag, 32'(ram_rdata), 32'(exp));
   endtask

   initial begin
      int n;
      // ---------------- reset state
      #12;
      chk("reset_load_count", 32'(load_count), 32'd0);
      chk("reset_cpu_run", 32'(cpu_run), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("reset_load_ready", 32'(load_ready), 32'd1);

      // ---------------- word 0, then a gap with a processor write attempt to address 0
      @(posedge clk); #1;
      load_valid = 1'b1; load_data = 16'h0100;
      step();
      load_valid = 1'b0;
      ram_write_enable = 1'b1; ram_addr = '0; ram_wdata = 16'hDEAD;
      step();
      step();
      ram_write_enable = 1'b0;
      chk("gap_load_count", 32'(load_count), 32'd1);
      read_chk("load_we_ignored_addr0", 0, 16'h0100);

      // ---------------- words 1..31 back-to-back, last flagged on 31
      for (int i = 1; i < 32; i++) begin
         load_valid = 1'b1; load_data = 16'h0100 + 16'(i);
         load_last = (i == 31);
         if (i == 31) chk("pre_last_cpu_run", 32'(cpu_run), 32'd0);
         step();
      end
      load_valid = 1'b0; load_last = 1'b0;
      chk("full_load_count", 32'(load_count), 32'd32);
      chk("full_cpu_run", 32'(cpu_run), 32'd1);
      chk("full_load_ready", 32'(load_ready), 32'd0);
      read_chk("full_addr5", 5, 16'h0105);
      read_chk("full_addr31", 31, 16'h011F);

      // ---------------- RUN-mode write, loader held valid
      load_valid = 1'b1; load_data = 16'h5555;
      ram_addr = 5'd7; ram_wdata = 16'hBEEF; ram_write_enable = 1'b1;
      #1;
      chk("run_old_before_edge", 32'(ram_rdata), 32'h0107);
      chk("run_load_ready", 32'(load_ready), 32'd0);
      step();
      ram_write_enable = 1'b0;
      #1;
      chk("run_new_after_edge", 32'(ram_rdata), 32'hBEEF);
      step();
      chk("run_load_ready_held", 32'(load_ready), 32'd0);
      chk("run_load_count_held", 32'(load_count), 32'd32);
      load_valid = 1'b0;

      // ---------------- reload 10 words of FFFF, then async reset mid-LOAD
      rst_n = 1'b0; #2; rst_n = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         load_valid = 1'b1; load_data = 16'hFFFF;
         step();
      end
      load_valid = 1'b0;
      chk("mid_load_count", 32'(load_count), 32'd10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_load_count", 32'(load_count), 32'd0);
      chk("async_rst_cpu_run", 32'(cpu_run), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rst_load_ready", 32'(load_ready), 32'd1);

      // ---------------- 3-word image, last on the third; load_last alone is inert
      load_valid = 1'b1; load_data = 16'h0A00;
      step();
      load_valid = 1'b0; load_last = 1'b1;
      step();
      chk("last_no_valid_ready", 32'(load_ready), 32'd1);
      chk("last_no_valid_count", 32'(load_count), 32'd1);
      load_last = 1'b0;
      read_chk("reload_addr0", 0, 16'h0A00);
      read_chk("old_addr10_persists", 10, 16'h010A);
      load_valid = 1'b1; load_data = 16'h0A01;
      step();
      load_data = 16'h0A02; load_last = 1'b1;
      step();
      load_valid = 1'b0; load_last = 1'b0;
      n = 0;
      while (!cpu_run && n < 100) begin
         chk("fill_load_ready", 32'(load_ready), 32'd0);
         step();
         n++;
      end
      chk("fill_cycles", 32'(n), 32'(EXP_FILL_CYCLES));
      chk("short_cpu_run", 32'(cpu_run), 32'd1);
      chk("short_load_count", 32'(load_count), 32'd3);
      read_chk("short_addr2", 2, 16'h0A02);
`ifdef K_AND_S_MEM_ZERO_FILL_EN
      read_chk("fill_addr3", 3, 16'h0000);
      read_chk("fill_addr10", 10, 16'h0000);
      read_chk("fill_addr31", 31, 16'h0000);
`else
      read_chk("nofill_addr3", 3, 16'hFFFF);
      read_chk("nofill_addr10", 10, 16'h010A);
      read_chk("nofill_addr31", 31, 16'h011F);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/k_and_s_program_memory.md
K_AND_S_PROGRAM_MEMORY -- requirements
Module: k_and_s_program_memory

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width; depth = 2**ADDR_W words (32).
REQ-002 Parameter DATA_W, default 16, word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 load_valid  input  1  loader word valid.
REQ-006 load_data  input  DATA_W  loader word.
REQ-007 load_last  input  1  marks final loader word; qualified by load_valid.
REQ-008 load_ready  output  1  block accepts a loader word this cycle.
REQ-009 load_count  output  ADDR_W+1  number of loader words accepted since reset (0..32).
REQ-010 cpu_run  output  1  memory image complete; processor released.
REQ-011 ram_addr  input  ADDR_W  processor word address.
REQ-012 ram_write_enable  input  1  processor store strobe.
REQ-013 ram_wdata  input  DATA_W  processor store data (processor data_out).
REQ-014 ram_rdata  output  DATA_W  read data to processor (processor data_in).

Function
REQ-015 Storage SHALL be a 2**ADDR_W x DATA_W array; array contents SHALL NOT be reset.
REQ-016 ram_rdata SHALL equal mem[ram_addr] combinationally (zero-latency read) in every state.
REQ-017 FSM states SHALL be LOAD, FILL, RUN; encoding per shared package enum.
REQ-018 LOAD: load_ready=1, cpu_run=0; on load_valid&&load_ready, mem[ptr]<=load_data, ptr<=ptr+1, load_count<=load_count+1.
REQ-019 LOAD -> RUN on an accepted word when ptr==2**ADDR_W-1 (array full), regardless of load_last.
REQ-020 LOAD on accepted word with load_last and ptr<2**ADDR_W-1: -> FILL if fill compiled in, else -> RUN.
REQ-021 FILL: load_ready=0, cpu_run=0; each cycle mem[ptr]<=0, ptr<=ptr+1; after writing address 2**ADDR_W-1 -> RUN. load_count SHALL NOT change in FILL.
REQ-022 RUN: load_ready=0, cpu_run=1; on ram_write_enable, mem[ram_addr]<=ram_wdata at the rising edge. RUN is terminal until reset.
REQ-023 ram_write_enable in LOAD or FILL SHALL be ignored (no array write).
REQ-024 load_valid in FILL or RUN SHALL be ignored; words are not consumed (load_ready=0).
REQ-025 Same-cycle write and read of one address in RUN: ram_rdata shows old data until the edge, new data after.
REQ-026 ptr SHALL be ADDR_W bits and SHALL NOT wrap past the last word in LOAD/FILL; load_count saturates at 32.
REQ-027 load_last with load_valid=0 SHALL have no effect.

Reset
REQ-028 On rst_n low: state=LOAD, ptr=0, load_count=0, cpu_run=0, load_ready=1 (after reset release), immediately and asynchronously.
REQ-029 Reset asserted mid-LOAD or mid-FILL SHALL abort; reload restarts at address 0; old array contents persist until overwritten.

Configuration
REQ-030 Macro K_AND_S_MEM_ZERO_FILL_EN defined: FILL state present; words after the last loaded address are cleared before cpu_run rises.
REQ-031 Macro undefined: FILL state absent; load_last goes directly to RUN; unloaded words keep prior contents; FILL enum value unused.

Structure
REQ-032 Shared package k_and_s_pkg SHALL hold the memory FSM state enum (LOAD, FILL, RUN) and the ADDR_W/DATA_W defaults.
REQ-033 No sub-module; array, pointer and FSM in one module; no processor-side dependency beyond the listed ports.

Verification
REQ-034 Reset, stream 32 words 16'h0100+i back-to-back -> load_count=32, cpu_run=1 the cycle after word 31; ram_addr=5 reads 16'h0105.
REQ-035 With K_AND_S_MEM_ZERO_FILL_EN: 3 words with last on third -> 29 FILL cycles, then cpu_run=1; ram_addr=3..31 read 16'h0000, load_count=3.
REQ-036 Without macro: same stimulus over preloaded 16'hFFFF -> cpu_run=1 next cycle; ram_addr=3 reads 16'hFFFF.
REQ-037 In RUN, ram_addr=7, ram_wdata=16'hBEEF, ram_write_enable=1 one cycle -> ram_rdata=16'hBEEF after edge; load_valid held high -> load_ready stays 0.
REQ-038 ram_write_enable=1 to address 0 during LOAD -> mem[0] unchanged; load_valid gaps -> ptr holds, no spurious write.
REQ-039 rst_n low after 10 loaded words -> load_count=0, cpu_run=0 asynchronously; next word writes address 0.
